// File: rtl/isa_pkg.sv
// Shared state encoding, lane constants and read-lane helper for the ISA I/O responder.
package isa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    // Observation bundle: FSM state plus the synchronised strobe edge events.
    typedef struct packed {
        state_e state;
        logic   ior_fall;
        logic   iow_fall;
        logic   aen_fall;
    } dbg_t;

    localparam logic [1:0]  BE_LO      = 2'b01;
    localparam logic [1:0]  BE_HI      = 2'b10;
    localparam logic [1:0]  BE_WORD    = 2'b11;
    localparam logic [15:0] READ_FLOAT = 16'hFFFF;

    // Places register read data onto the ISA lanes selected by the byte enables.
    function automatic logic [15:0] lane_read(input logic [1:0] be, input logic [15:0] rdata);
        case (be)
            BE_WORD: lane_read = rdata;
            BE_HI:   lane_read = {8'h00, rdata[15:8]};
            default: lane_read = {8'h00, rdata[7:0]};
        endcase
    endfunction

endpackage

// File: rtl/isa_io_responder_if.sv
// ISA slot signals and internal register-bus signals seen by the I/O responder.
// Register bus: reg_rd/reg_wr is a one-cycle request with addr/be/wdata held stable
// until reg_ack; reg_ack (with reg_rdata for reads) completes it; one request outstanding at most.
interface isa_io_responder_if #(
    parameter int WINDOW_BITS = 3
);
    logic [15:0]            isa_sa;
    logic                   isa_aen;
    logic                   isa_ior_n;
    logic                   isa_iow_n;
    logic                   isa_sbhe_n;
    logic [15:0]            isa_d_in;
    logic [15:0]            isa_d_out;
    logic                   isa_d_oe_lo;
    logic                   isa_d_oe_hi;
    logic                   isa_iocs16_n;
    logic                   iochrdy_low;
    logic                   enable_high_byte;
    logic [WINDOW_BITS-1:0] reg_addr;
    logic [1:0]             reg_be;
    logic [15:0]            reg_wdata;
    logic                   reg_wr;
    logic                   reg_rd;
    logic [15:0]            reg_rdata;
    logic                   reg_ack;
    logic                   timeout_err;

    // slave: the responder (ISA target, register-bus requester); master: host + register bank.
    modport slave (
        input  isa_sa, isa_aen, isa_ior_n, isa_iow_n, isa_sbhe_n, isa_d_in, enable_high_byte,
               reg_rdata, reg_ack,
        output isa_d_out, isa_d_oe_lo, isa_d_oe_hi, isa_iocs16_n, iochrdy_low,
               reg_addr, reg_be, reg_wdata, reg_wr, reg_rd, timeout_err
    );

    modport master (
        output isa_sa, isa_aen, isa_ior_n, isa_iow_n, isa_sbhe_n, isa_d_in, enable_high_byte,
               reg_rdata, reg_ack,
        input  isa_d_out, isa_d_oe_lo, isa_d_oe_hi, isa_iocs16_n, iochrdy_low,
               reg_addr, reg_be, reg_wdata, reg_wr, reg_rd, timeout_err
    );
endinterface

// File: rtl/isa_strobe_sync.sv
// Multi-flop synchroniser for an active-low ISA control line, idling high,
// with a falling-edge flag derived from registered samples.
module isa_strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_last <= 1'b1;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_last <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_fall = r_last & ~r_sync[STAGES-1];
endmodule

// File: rtl/isa_io_responder.sv
// ISA I/O-cycle target: decodes the port window, issues one register-bus access per
// host cycle, stretches the cycle with IOCHRDY and drives read data back onto the bus.
module isa_io_responder
    import isa_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'h03F0,
    parameter int          WINDOW_BITS  = 3,
    parameter int          WAIT_TIMEOUT = 64,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    isa_io_responder_if.slave bus,
    output dbg_t              o_dbg
);
    localparam int            CW       = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);

    logic w_ior_s, w_iow_s, w_aen_s, w_ior_fall, w_iow_fall, w_aen_fall;

    isa_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_ior (
        .clk(clk), .rst_n(rst_n), .i_async(bus.isa_ior_n), .o_sync(w_ior_s), .o_fall(w_ior_fall));
    isa_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_iow (
        .clk(clk), .rst_n(rst_n), .i_async(bus.isa_iow_n), .o_sync(w_iow_s), .o_fall(w_iow_fall));
    isa_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_aen (
        .clk(clk), .rst_n(rst_n), .i_async(bus.isa_aen), .o_sync(w_aen_s), .o_fall(w_aen_fall));

    state_e                 r_state, w_state_nx;
    logic [WINDOW_BITS-1:0] r_reg_addr, w_addr_nx;
    logic [1:0]             r_reg_be, w_be_nx;
    logic [15:0]            r_reg_wdata, w_wdata_nx;
    logic [15:0]            r_d_out, w_d_out_nx;
    logic [CW-1:0]          r_wait_cnt, w_cnt_nx;
    logic r_reg_rd, w_rd_nx, r_reg_wr, w_wr_nx, r_iochrdy_low, w_iochrdy_nx;
    logic r_timeout_err, w_tmo_nx, r_oe_lo, w_oe_lo_nx, r_oe_hi, w_oe_hi_nx;
    logic r_is_read, w_is_read_nx, r_iocs16_n;

    logic        w_hit, w_wide, w_start;
    logic [1:0]  w_be;
    logic [15:0] w_wdata;

    assign w_hit   = !w_aen_s && (bus.isa_sa[15:WINDOW_BITS] == BASE_ADDR[15:WINDOW_BITS]);
    assign w_wide  = bus.enable_high_byte && !bus.isa_sa[0] && !bus.isa_sbhe_n;
    // Both strobes falling together is a malformed cycle and is dropped.
    assign w_start = w_hit && (w_ior_fall ^ w_iow_fall);

    always_comb begin
        w_be    = BE_HI;
        w_wdata = {bus.isa_d_in[7:0], 8'h00};
        if (w_wide) begin
            w_be    = BE_WORD;
            w_wdata = bus.isa_d_in;
        end else if (!bus.isa_sa[0]) begin
            w_be    = BE_LO;
            w_wdata = {8'h00, bus.isa_d_in[7:0]};
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_addr_nx    = r_reg_addr;
        w_be_nx      = r_reg_be;
        w_wdata_nx   = r_reg_wdata;
        w_d_out_nx   = r_d_out;
        w_cnt_nx     = r_wait_cnt;
        w_rd_nx      = 1'b0;
        w_wr_nx      = 1'b0;
        w_tmo_nx     = 1'b0;
        w_iochrdy_nx = r_iochrdy_low;
        w_oe_lo_nx   = r_oe_lo;
        w_oe_hi_nx   = r_oe_hi;
        w_is_read_nx = r_is_read;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    // Wide accesses are even by definition, so the offset needs no masking.
                    w_addr_nx    = bus.isa_sa[WINDOW_BITS-1:0];
                    w_be_nx      = w_be;
                    w_wdata_nx   = w_wdata;
                    w_is_read_nx = w_ior_fall;
                    w_rd_nx      = w_ior_fall;
                    w_wr_nx      = w_iow_fall;
                    w_iochrdy_nx = 1'b1;
                    w_cnt_nx     = '0;
                    w_state_nx   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_nx = r_wait_cnt + CW'(1);
                if (bus.reg_ack || (r_wait_cnt == CNT_LAST)) begin
                    w_iochrdy_nx = 1'b0;
                    w_tmo_nx     = !bus.reg_ack;
                    w_state_nx   = ST_ACTIVE;
                    if (r_is_read) begin
                        w_d_out_nx = bus.reg_ack ? lane_read(r_reg_be, bus.reg_rdata) : READ_FLOAT;
                        w_oe_lo_nx = 1'b1;
                        w_oe_hi_nx = (r_reg_be == BE_WORD);
                    end
                end
            end
            ST_ACTIVE: begin
                if (r_is_read ? w_ior_s : w_iow_s) begin
                    w_oe_lo_nx = 1'b0;
                    w_oe_hi_nx = 1'b0;
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_reg_addr    <= '0;
            r_reg_be      <= '0;
            r_reg_wdata   <= '0;
            r_d_out       <= '0;
            r_wait_cnt    <= '0;
            r_reg_rd      <= 1'b0;
            r_reg_wr      <= 1'b0;
            r_iochrdy_low <= 1'b0;
            r_timeout_err <= 1'b0;
            r_oe_lo       <= 1'b0;
            r_oe_hi       <= 1'b0;
            r_is_read     <= 1'b0;
            r_iocs16_n    <= 1'b1;
        end else begin
            r_state       <= w_state_nx;
            r_reg_addr    <= w_addr_nx;
            r_reg_be      <= w_be_nx;
            r_reg_wdata   <= w_wdata_nx;
            r_d_out       <= w_d_out_nx;
            r_wait_cnt    <= w_cnt_nx;
            r_reg_rd      <= w_rd_nx;
            r_reg_wr      <= w_wr_nx;
            r_iochrdy_low <= w_iochrdy_nx;
            r_timeout_err <= w_tmo_nx;
            r_oe_lo       <= w_oe_lo_nx;
            r_oe_hi       <= w_oe_hi_nx;
            r_is_read     <= w_is_read_nx;
            r_iocs16_n    <= !(w_hit && bus.enable_high_byte && !bus.isa_sa[0]);
        end
    end

    assign bus.isa_d_out    = r_d_out;
    assign bus.isa_d_oe_lo  = r_oe_lo;
    assign bus.isa_d_oe_hi  = r_oe_hi;
    assign bus.isa_iocs16_n = r_iocs16_n;
    assign bus.iochrdy_low  = r_iochrdy_low;
    assign bus.reg_addr     = r_reg_addr;
    assign bus.reg_be       = r_reg_be;
    assign bus.reg_wdata    = r_reg_wdata;
    assign bus.reg_wr       = r_reg_wr;
    assign bus.reg_rd       = r_reg_rd;
    assign bus.timeout_err  = r_timeout_err;

    assign o_dbg = '{state: r_state, ior_fall: w_ior_fall, iow_fall: w_iow_fall, aen_fall: w_aen_fall};
endmodule

// File: tb/tb_isa_io_responder.sv
// Directed and randomized ISA I/O cycles against a port-window reference model.
module tb_isa_io_responder;
    import isa_pkg::*;

    localparam logic [15:0] BASE = 16'h03F0;
    localparam int          WIN  = 8;
    localparam int          TMO  = 64;
    localparam int          W    = 21;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    dbg_t dbg;
    int   n_vectors     = 0;
    int   n_miscompares = 0;
    logic [W-1:0] exp_q[$];

    isa_io_responder_if #(.WINDOW_BITS(3)) bus ();

    isa_io_responder #(
        .BASE_ADDR(BASE), .WINDOW_BITS(3), .WAIT_TIMEOUT(TMO), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .o_dbg(dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Expected request {offset, byte enables, write data} for one host cycle.
    function automatic logic [W-1:0] model_req(input logic [15:0] addr, input bit sbhe_n,
                                               input bit ehb, input logic [15:0] d);
        int          off;
        bit          even, wide;
        logic [1:0]  be;
        logic [15:0] wd;
        off  = int'(addr) - int'(BASE);
        even = (addr % 2 == 0);
        wide = ehb && even && !sbhe_n;
        be   = wide ? 2'd3 : (even ? 2'd1 : 2'd2);
        wd   = wide ? d : (even ? 16'(d % 256) : 16'((d % 256) * 256));
        return {off[2:0], be, wd};
    endfunction

    // ---------------- driver ----------------
    task automatic do_cycle(input bit is_rd, input logic [15:0] addr, input bit aen,
                            input bit sbhe_n, input bit ehb, input logic [15:0] din,
                            input logic [15:0] rdata, input int ack_dly);
        bit           hit, even, wide, timed_out, done;
        logic [W-1:0] exp_rec;
        logic [15:0]  exp_dout;
        int           hi_cnt;
        hit       = !aen && (int'(addr) >= int'(BASE)) && (int'(addr) < int'(BASE) + WIN);
        even      = (addr % 2 == 0);
        wide      = ehb && even && !sbhe_n;
        timed_out = (ack_dly <= 0);
        exp_dout  = timed_out ? 16'hFFFF : (wide ? rdata : (even ? 16'(rdata % 256) : 16'(rdata / 256)));

        @(negedge clk);
        bus.isa_sa           = addr;
        bus.isa_aen          = aen;
        bus.isa_sbhe_n       = sbhe_n;
        bus.enable_high_byte = ehb;
        bus.isa_d_in         = din;
        repeat (3) @(negedge clk);
        check("iocs16_n", 32'(bus.isa_iocs16_n), 32'(!(hit && ehb && even)));
        if (hit) exp_q.push_back(model_req(addr, sbhe_n, ehb, din));

        if (is_rd) bus.isa_ior_n = 1'b0;
        else       bus.isa_iow_n = 1'b0;
        repeat (2) @(negedge clk);
        check("req_early", 32'({bus.reg_rd, bus.reg_wr}), 32'(2'b00));
        @(negedge clk);
        check("req", 32'({bus.reg_rd, bus.reg_wr}), 32'(hit ? (is_rd ? 2'b10 : 2'b01) : 2'b00));
        check("iochrdy_assert", 32'(bus.iochrdy_low), 32'(hit));

        if (hit) begin
            exp_rec = exp_q.pop_front();
            check("addr_be", 32'({bus.reg_addr, bus.reg_be}), 32'(exp_rec[W-1:16]));
            if (!is_rd) check("wdata", 32'(bus.reg_wdata), 32'(exp_rec[15:0]));
            hi_cnt = 1;
            done   = 1'b0;
            for (int j = 1; j <= TMO + 4 && !done; j++) begin
                bus.reg_ack   = (j == ack_dly);
                bus.reg_rdata = rdata;
                @(negedge clk);
                if (j == 1) check("req_pulse", 32'({bus.reg_rd, bus.reg_wr}), 32'(2'b00));
                if (bus.iochrdy_low) hi_cnt++;
                else                 done = 1'b1;
            end
            bus.reg_ack = 1'b0;
            check("iochrdy_len", 32'(hi_cnt), 32'(timed_out ? TMO : ack_dly));
            check("timeout_err", 32'(bus.timeout_err), 32'(timed_out));
            check("oe", 32'({bus.isa_d_oe_hi, bus.isa_d_oe_lo}), 32'(is_rd ? {wide, 1'b1} : 2'b00));
            if (is_rd) check("d_out", 32'(bus.isa_d_out), 32'(exp_dout));
            // A late acknowledge after expiry must change nothing.
            bus.reg_ack = timed_out;
        end else begin
            repeat (2) begin
                @(negedge clk);
                check("miss_quiet", 32'({bus.reg_rd, bus.reg_wr, bus.iochrdy_low,
                                         bus.isa_d_oe_hi, bus.isa_d_oe_lo}), 32'(5'b0));
            end
        end

        bus.isa_ior_n = 1'b1;
        bus.isa_iow_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            bus.reg_ack = 1'b0;
            check("oe_hold", 32'({bus.isa_d_oe_hi, bus.isa_d_oe_lo}),
                  32'((hit && is_rd) ? {wide, 1'b1} : 2'b00));
            check("timeout_err_pulse", 32'(bus.timeout_err), 32'(1'b0));
        end
        if (hit && is_rd) check("d_out_hold", 32'(bus.isa_d_out), 32'(exp_dout));
        @(negedge clk);
        check("oe_release", 32'({bus.isa_d_oe_hi, bus.isa_d_oe_lo}), 32'(2'b00));
        check("state_idle", 32'(dbg.state), 32'(ST_IDLE));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] addr;
        int          sel;
        bus.isa_sa           = 16'h0000;
        bus.isa_aen          = 1'b0;
        bus.isa_ior_n        = 1'b1;
        bus.isa_iow_n        = 1'b1;
        bus.isa_sbhe_n       = 1'b1;
        bus.isa_d_in         = 16'h0000;
        bus.enable_high_byte = 1'b0;
        bus.reg_rdata        = 16'h0000;
        bus.reg_ack          = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_d_out", 32'(bus.isa_d_out), 32'h0);
        check("rst_oe", 32'({bus.isa_d_oe_hi, bus.isa_d_oe_lo}), 32'h0);
        check("rst_iocs16_n", 32'(bus.isa_iocs16_n), 32'h1);
        check("rst_iochrdy", 32'(bus.iochrdy_low), 32'h0);
        check("rst_reg", 32'({bus.reg_addr, bus.reg_be, bus.reg_wr, bus.reg_rd, bus.timeout_err}), 32'h0);
        check("rst_wdata", 32'(bus.reg_wdata), 32'h0);
        check("rst_state", 32'(dbg.state), 32'(ST_IDLE));
        rst_n = 1'b1;

        // 1: 16-bit write, ack after 3 clocks
        do_cycle(1'b0, 16'h03F2, 1'b0, 1'b0, 1'b1, 16'hA55A, 16'h0000, 3);
        // 2: 8-bit read of odd port
        do_cycle(1'b1, 16'h03F3, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h12AB, 2);
        // 3: read with no acknowledge
        do_cycle(1'b1, 16'h03F0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234, 0);
        // 4: DMA cycle and out-of-window address
        do_cycle(1'b1, 16'h03F0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h5555, 1);
        do_cycle(1'b1, 16'h03E8, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5555, 1);
        // Minimum stretch: acknowledge alongside the request
        do_cycle(1'b0, 16'h03F5, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 1);

        // 5: reset during WAIT
        @(negedge clk);
        bus.isa_sa           = 16'h03F4;
        bus.isa_aen          = 1'b0;
        bus.enable_high_byte = 1'b1;
        bus.isa_sbhe_n       = 1'b1;
        repeat (3) @(negedge clk);
        bus.isa_ior_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_req", 32'(bus.reg_rd), 32'h1);
        repeat (4) @(negedge clk);
        check("t5_waiting", 32'(bus.iochrdy_low), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_iochrdy_rst", 32'(bus.iochrdy_low), 32'h0);
        check("t5_oe_rst", 32'({bus.isa_d_oe_hi, bus.isa_d_oe_lo}), 32'h0);
        check("t5_state_rst", 32'(dbg.state), 32'(ST_IDLE));
        bus.isa_ior_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(1'b1, 16'h03F6, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hC3A5, 2);

        // 6: both strobes fall together
        @(negedge clk);
        bus.isa_sa = 16'h03F1;
        repeat (3) @(negedge clk);
        bus.isa_ior_n = 1'b0;
        bus.isa_iow_n = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("t6_no_req", 32'({bus.reg_rd, bus.reg_wr, bus.iochrdy_low}), 32'h0);
            check("t6_idle", 32'(dbg.state), 32'(ST_IDLE));
        end
        bus.isa_ior_n = 1'b1;
        bus.isa_iow_n = 1'b1;
        repeat (4) @(negedge clk);

        // Randomized cycles
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       addr = BASE + 16'($urandom_range(0, WIN - 1));
            else if (sel == 7) addr = 16'h03E8 + 16'($urandom_range(0, 7));
            else               addr = 16'($urandom_range(0, 65535));
            do_cycle(1'($urandom_range(0, 1)), addr, ($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     16'($urandom), 16'($urandom), $urandom_range(1, 6));
        end

        check("exp_q_empty", 32'(exp_q.size()), 32'h0);

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule

// File: doc/isa_io_responder.md
Name: isa_io_responder

Overview:
- ISA I/O-cycle target for the FluxRipper card. It answers host IOR#/IOW# cycles inside a fixed address window and translates each one into a single-transaction internal register-bus access.
- It extends cycles via IOCHRDY until the register bus acknowledges.
- It consumes `enable_high_byte` from slot-width detection to choose 16-bit (AT) or 8-bit (XT) transfers and to drive IOCS16#.

Parameters:
- BASE_ADDR, 16'h03F0, I/O window base; low WINDOW_BITS bits ignored.
- WINDOW_BITS, 3, window size 2^WINDOW_BITS ports; also `reg_addr` width.
- WAIT_TIMEOUT, 64, max clk cycles IOCHRDY is held low awaiting `reg_ack`.
- SYNC_STAGES, 2, synchronizer depth for `isa_ior_n`, `isa_iow_n`, `isa_aen`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- isa_sa  in  16  ISA address SA15..SA0
- isa_aen  in  1  DMA address enable (high = not an I/O cycle for us)
- isa_ior_n  in  1  I/O read strobe
- isa_iow_n  in  1  I/O write strobe
- isa_sbhe_n  in  1  system byte-high enable
- isa_d_in  in  16  data bus from transceivers
- isa_d_out  out  16  data bus to transceivers
- isa_d_oe_lo  out  1  drive D7..D0
- isa_d_oe_hi  out  1  drive D15..D8
- isa_iocs16_n  out  1  0 = pull IOCS16# low; 1 = released
- iochrdy_low  out  1  1 = pull IOCHRDY low (insert wait)
- enable_high_byte  in  1  1 = 16-bit slot/high lane usable
- reg_addr  out  WINDOW_BITS  register offset
- reg_be  out  2  byte enables, [0]=low byte, [1]=high byte
- reg_wdata  out  16  write data
- reg_wr  out  1  one-cycle write request
- reg_rd  out  1  one-cycle read request
- reg_rdata  in  16  read data, valid with `reg_ack`
- reg_ack  in  1  request complete
- timeout_err  out  1  one-cycle pulse on WAIT_TIMEOUT expiry

Behaviour:
- **Reset:** all outputs released or zero:
  - `isa_d_out`=0, both OEs=0, `isa_iocs16_n`=1, `iochrdy_low`=0.
  - `reg_*`=0, `timeout_err`=0, FSM=IDLE.
  - Strobe and AEN synchronizers reset to 1.
  - Reset mid-cycle releases the bus immediately.
- **Synchronization:** SYNC_STAGES flops on `isa_ior_n`, `isa_iow_n`, `isa_aen`. `isa_sa`, `isa_sbhe_n` and `isa_d_in` are sampled unsynchronized on the strobe-assert edge; ISA setup guarantees they are stable then.
- **Decode:**
  - `hit` = !aen_s && `isa_sa[15:WINDOW_BITS]` == `BASE_ADDR[15:WINDOW_BITS]`.
  - `wide` = `enable_high_byte` && !`isa_sa[0]` && !`isa_sbhe_n`.
- **IOCS16#:** registered; `isa_iocs16_n` = !(hit && `enable_high_byte` && !`isa_sa[0]`). Updated every cycle regardless of FSM state. Never asserted while `enable_high_byte`=0.
- **Lane mapping:**
  - wide: `reg_be`=11; `reg_wdata`=`isa_d_in`; read drives both lanes.
  - narrow even address: `reg_be`=01; `reg_wdata`={8'h00,`d_in[7:0]`}; read returns `rdata[7:0]` on D7..D0.
  - narrow odd address: `reg_be`=10; `reg_wdata`={`d_in[7:0]`,8'h00}; read returns `rdata[15:8]` on D7..D0.
  - `reg_addr` = `isa_sa[WINDOW_BITS-1:0]` with bit 0 cleared for wide accesses.
- **FSM:**
  - **IDLE**
    - Falling edge of synced IOR# or IOW#, with hit → latch addr/be/wdata.
    - Pulse `reg_rd` or `reg_wr` for exactly 1 cycle; set `iochrdy_low`=1; go to WAIT.
    - Both strobes asserting in the same cycle → ignored, stay in IDLE.
    - Miss → no action.
  - **WAIT**
    - Wait counter increments each cycle.
    - `reg_ack` → capture `reg_rdata` (reads); `iochrdy_low`=0; go to ACTIVE. `reg_ack` is allowed in the cycle right after the request, giving minimum IOCHRDY-low of 1 cycle.
    - Counter == WAIT_TIMEOUT-1 without ack → `iochrdy_low`=0; `timeout_err` pulses for 1 cycle; read data forced to 16'hFFFF; go to ACTIVE. A late `reg_ack` is ignored.
  - **ACTIVE**
    - Reads: OEs asserted per lane mapping; `isa_d_out` held.
    - When the synced strobe deasserts → OEs=0, go to IDLE. OEs drop the cycle after the strobe is seen high.
  - `reg_ack` in IDLE or ACTIVE is ignored.
- **Latency:** strobe edge to `reg_rd`/`reg_wr` = SYNC_STAGES+1 clk.
- **Single outstanding:** exactly one outstanding register transaction. No new cycle is accepted until the FSM returns to IDLE.

Decomposition:
- **Shared package `isa_pkg`:**
  - FSM state encoding (IDLE/WAIT/ACTIVE).
  - Byte-enable constants BE_LO=2'b01, BE_HI=2'b10, BE_WORD=2'b11.
  - Bus-float read value 16'hFFFF.
- **Sub-module `isa_strobe_sync`:** parameterised SYNC_STAGES synchronizer with registered falling-edge detect and reset value 1. Instantiated for IOR#, IOW# and AEN.

Test Plan:
1. `enable_high_byte`=1, IOW# to 0x3F2, SBHE#=0, D=16'hA55A → `isa_iocs16_n`=0; `reg_wr` pulse, `reg_addr`=2, `reg_be`=11, `reg_wdata`=A55A; ack after 3 clk → `iochrdy_low` high 3 clk then released.
2. `enable_high_byte`=0, IOR# to 0x3F3, `reg_rdata`=16'h12AB → `reg_be`=10; `isa_d_out[7:0]`=12; only `isa_d_oe_lo`=1; `isa_iocs16_n` stays 1.
3. No `reg_ack` on a read of 0x3F0 → `iochrdy_low` held exactly 64 clk; `timeout_err` 1-cycle pulse; D=FFFF returned.
4. AEN=1 or address 0x3E8 with IOR# → no `reg_rd`, no OE, `isa_iocs16_n`=1.
5. Assert rst_n low during WAIT → `iochrdy_low`=0 and OEs=0 immediately; after release, the next valid cycle completes normally.
6. IOR# and IOW# falling in the same cycle → no request issued, FSM remains IDLE.
